pe_flow_ctl: RTL and testbench

PE_FLOW_CTL -- requirements
Module: pe_flow_ctl

---
 rtl/pe_flow_ctl.sv | 170 +++++++++++++++++
 tb/tb_pe_flow_ctl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_flow_ctl.sv
// Processing-element flow controller: fills operand pads, steps the loop nest and pops reused operands.
// Latency: pointer, index and occupancy updates land the cycle after the fire; acks and ready are combinational from state and occupancy.
// Backpressure: operand ack drops when a pad is full; main ready drops while any pad is empty; i_stall freezes the job.
module pe_flow_ctl #(
    parameter int NOPND  = 2,
    parameter int NDEPTH = 4,
    parameter int IDXDW  = 8,
    parameter int ADDRW  = 5
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic                                  i_stall,
    input  logic                                  i_abort,
    input  logic [NDEPTH*IDXDW-1:0]               i_loop_size,
    input  logic [NOPND*(ADDRW+1)-1:0]            i_pad_size,
    input  logic [NOPND*$clog2(NDEPTH+1)-1:0]     i_pop_lvl,
    input  logic [NOPND-1:0]                      i_opnd_rdy,
    output logic [NOPND-1:0]                      o_opnd_ack,
    output logic                                  o_main_rdy,
    input  logic                                  i_main_ack,
    output logic [NOPND*ADDRW-1:0]                o_waddr,
    output logic [NOPND*ADDRW-1:0]                o_raddr,
    output logic [NOPND-1:0]                      o_write,
    output logic [NOPND-1:0]                      o_read,
    output logic [NDEPTH*IDXDW-1:0]               o_loop_idx,
    output logic [NDEPTH-1:0]                     o_loop_end,
    output logic [2:0]                            o_state,
    output logic                                  o_done
);

    localparam int PLW  = $clog2(NDEPTH+1);
    localparam int OCCW = ADDRW + 1;
    localparam logic [OCCW-1:0]  OCC1 = OCCW'(1);
    localparam logic [ADDRW-1:0] ADR1 = ADDRW'(1);
    localparam logic [IDXDW-1:0] IDX1 = IDXDW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        WORK  = 3'd2,
        STALL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [IDXDW-1:0] size_q [NDEPTH];
    logic [IDXDW-1:0] idx_q  [NDEPTH];
    logic [OCCW-1:0]  pad_q  [NOPND];
    logic [OCCW-1:0]  occ_q  [NOPND];
    logic [PLW-1:0]   plvl_q [NOPND];
    logic [ADDRW-1:0] wptr_q [NOPND];
    logic [ADDRW-1:0] rptr_q [NOPND];

    logic [NDEPTH-1:0] lvl_end;
    logic [NDEPTH:0]   pre_end;
    logic [NOPND-1:0]  ack, has_data, ofire, pop;
    logic              main_rdy, main_fire, final_fire;

    function automatic logic [ADDRW-1:0] ptr_nxt(input logic [ADDRW-1:0] p, input logic [OCCW-1:0] sz);
        return ({1'b0, p} == sz - OCC1) ? '0 : p + ADR1;
    endfunction

    // pre_end[j]: every level below j sits on its last index (size 0 behaves as 1)
    always_comb begin
        pre_end = '0;
        pre_end[0] = 1'b1;
        for (int j = 0; j < NDEPTH; j++) begin
            lvl_end[j]     = (idx_q[j] == ((size_q[j] == '0) ? '0 : size_q[j] - IDX1));
            pre_end[j + 1] = pre_end[j] & lvl_end[j];
        end
    end

    always_comb begin
        for (int k = 0; k < NOPND; k++) begin
            ack[k]      = (state == WORK) && (occ_q[k] < pad_q[k]);
            has_data[k] = (occ_q[k] != '0);
            ofire[k]    = ack[k] & i_opnd_rdy[k];
        end
        main_rdy   = (state == WORK) && (&has_data);
        main_fire  = main_rdy & i_main_ack;
        final_fire = main_fire & pre_end[NDEPTH];
        // reuse levels beyond NDEPTH behave like NDEPTH (pop once per job)
        for (int k = 0; k < NOPND; k++) begin
            pop[k] = main_fire & pre_end[NDEPTH];
            for (int j = 0; j < NDEPTH; j++) begin
                if (plvl_q[k] == PLW'(j)) pop[k] = main_fire & pre_end[j];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = INIT;
            INIT:    state_nxt = WORK;
            WORK:    if (final_fire) state_nxt = DONE;
                     else if (i_stall) state_nxt = STALL;
            STALL:   if (!i_stall) state_nxt = WORK;
            DONE:    if (i_start) state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
        if (i_abort) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            for (int j = 0; j < NDEPTH; j++) begin
                size_q[j] <= '0;
                idx_q[j]  <= '0;
            end
            for (int k = 0; k < NOPND; k++) begin
                pad_q[k]  <= '0;
                occ_q[k]  <= '0;
                plvl_q[k] <= '0;
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (i_abort || state == INIT) begin
                for (int j = 0; j < NDEPTH; j++) idx_q[j] <= '0;
                for (int k = 0; k < NOPND; k++) begin
                    occ_q[k]  <= '0;
                    wptr_q[k] <= '0;
                    rptr_q[k] <= '0;
                end
                if (!i_abort) begin
                    for (int j = 0; j < NDEPTH; j++) size_q[j] <= i_loop_size[j*IDXDW +: IDXDW];
                    for (int k = 0; k < NOPND; k++) begin
                        pad_q[k]  <= i_pad_size[k*OCCW +: OCCW];
                        plvl_q[k] <= i_pop_lvl[k*PLW +: PLW];
                    end
                end
            end else begin
                for (int j = 0; j < NDEPTH; j++) begin
                    if (main_fire && pre_end[j]) idx_q[j] <= lvl_end[j] ? '0 : idx_q[j] + IDX1;
                end
                for (int k = 0; k < NOPND; k++) begin
                    if (ofire[k]) wptr_q[k] <= ptr_nxt(wptr_q[k], pad_q[k]);
                    if (pop[k])   rptr_q[k] <= ptr_nxt(rptr_q[k], pad_q[k]);
                    case ({ofire[k], pop[k]})
                        2'b10:   occ_q[k] <= occ_q[k] + OCC1;
                        2'b01:   occ_q[k] <= occ_q[k] - OCC1;
                        default: occ_q[k] <= occ_q[k];
                    endcase
                end
            end
        end
    end

    for (genvar k = 0; k < NOPND; k++) begin : g_opnd
        assign o_waddr[k*ADDRW +: ADDRW] = wptr_q[k];
        assign o_raddr[k*ADDRW +: ADDRW] = rptr_q[k];
    end
    for (genvar j = 0; j < NDEPTH; j++) begin : g_lvl
        assign o_loop_idx[j*IDXDW +: IDXDW] = idx_q[j];
    end

    assign o_opnd_ack = ack;
    assign o_main_rdy = main_rdy;
    assign o_write    = ofire;
    assign o_read     = {NOPND{main_fire}};
    assign o_loop_end = (state == IDLE) ? '0 : lvl_end;
    assign o_state    = state;
    assign o_done     = (state == DONE);

endmodule

// File: tb/tb_pe_flow_ctl.sv
// Directed bench for pe_flow_ctl with default parameters (2 operands, depth 4, 8-bit indices, 5-bit addresses).
module tb_pe_flow_ctl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start, i_stall, i_abort;
    logic [31:0] i_loop_size;
    logic [11:0] i_pad_size;
    logic [5:0]  i_pop_lvl;
    logic [1:0]  i_opnd_rdy;
    logic [1:0]  o_opnd_ack;
    logic        o_main_rdy;
    logic        i_main_ack;
    logic [9:0]  o_waddr, o_raddr;
    logic [1:0]  o_write, o_read;
    logic [31:0] o_loop_idx;
    logic [3:0]  o_loop_end;
    logic [2:0]  o_state;
    logic        o_done;

    int n_chk  = 0;
    int n_fail = 0;

    // per-fire expectations for sizes {2,3,1,1}, pop_lvl {0,1}, pad {4,2}
    int exp_i0[7]  = '{0, 1, 0, 1, 0, 1, 0};
    int exp_i1[7]  = '{0, 0, 1, 1, 2, 2, 0};
    int exp_r0[6]  = '{0, 1, 2, 3, 0, 1};
    int exp_r1[6]  = '{0, 0, 1, 1, 0, 0};
    int exp_end[6] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    pe_flow_ctl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stall    (i_stall),
        .i_abort    (i_abort),
        .i_loop_size(i_loop_size),
        .i_pad_size (i_pad_size),
        .i_pop_lvl  (i_pop_lvl),
        .i_opnd_rdy (i_opnd_rdy),
        .o_opnd_ack (o_opnd_ack),
        .o_main_rdy (o_main_rdy),
        .i_main_ack (i_main_ack),
        .o_waddr    (o_waddr),
        .o_raddr    (o_raddr),
        .o_write    (o_write),
        .o_read     (o_read),
        .o_loop_idx (o_loop_idx),
        .o_loop_end (o_loop_end),
        .o_state    (o_state),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int c = 0;
        while (o_state != s && c < budget) begin
            tick();
            c++;
        end
        if (o_state != s) chk("wait_state_timeout", 32'(o_state), 32'(s));
    endtask

    task automatic run_job(input int stall_at);
        int n = 0;
        int scnt = 0;
        pulse_start();
        for (int c = 0; c < 80; c++) begin
            tick();
            if (o_state == 3'd4) break;
            if (i_stall) begin
                chk("stall_state", 32'(o_state), 32'd3);
                chk("stall_strobes", {28'd0, o_write, o_read}, 32'd0);
                chk("stall_ackrdy", {29'd0, o_opnd_ack, o_main_rdy}, 32'd0);
                chk("stall_idx", {16'd0, o_loop_idx[15:0]}, 32'(exp_i1[n] * 256 + exp_i0[n]));
                scnt++;
                if (scnt == 3) i_stall = 1'b0;
            end else if (o_main_rdy && i_main_ack) begin
                if (n < 6) begin
                    chk("fire_idx0", 32'(o_loop_idx[7:0]), 32'(exp_i0[n]));
                    chk("fire_idx1", 32'(o_loop_idx[15:8]), 32'(exp_i1[n]));
                    chk("fire_raddr0", 32'(o_raddr[4:0]), 32'(exp_r0[n]));
                    chk("fire_raddr1", 32'(o_raddr[9:5]), 32'(exp_r1[n]));
                    chk("fire_end", 32'(o_loop_end), 32'(exp_end[n]));
                    chk("fire_read", 32'(o_read), 32'd3);
                end
                n++;
                if (stall_at > 0 && n == stall_at && scnt == 0) i_stall = 1'b1;
            end
        end
        chk("job_fires", 32'(n), 32'd6);
        chk("job_state", 32'(o_state), 32'd4);
        chk("job_done", 32'(o_done), 32'd1);
        chk("job_idx_wrap", o_loop_idx, 32'd0);
    endtask

    initial begin
        int f0, f1, nz;
        i_rst = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
        i_loop_size = {8'd1, 8'd1, 8'd3, 8'd2};
        i_pad_size  = {6'd2, 6'd4};
        i_pop_lvl   = {3'd1, 3'd0};
        i_opnd_rdy  = 2'b11;
        i_main_ack  = 1'b1;
        tick();
        tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_done_rdy", {30'd0, o_done, o_main_rdy}, 32'd0);
        chk("rst_ack", 32'(o_opnd_ack), 32'd0);
        chk("rst_strobes", {28'd0, o_write, o_read}, 32'd0);
        chk("rst_addr", {12'd0, o_waddr, o_raddr}, 32'd0);
        chk("rst_idx", o_loop_idx, 32'd0);
        chk("rst_end", 32'(o_loop_end), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("idle_end", 32'(o_loop_end), 32'd0);

        // full job, then again from DONE with a 3-cycle stall after the third fire
        run_job(0);
        run_job(3);

        // abort with start while occupancy is {2,1}
        i_main_ack = 1'b0;
        i_opnd_rdy = 2'b11;
        pulse_start();
        wait_state(3'd2, 10);
        tick();
        i_opnd_rdy = 2'b01;
        tick();
        i_opnd_rdy = 2'b00;
        #1;
        chk("pre_abort_waddr", 32'(o_waddr), {22'd0, 5'd1, 5'd2});
        i_abort = 1'b1;
        i_start = 1'b1;
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        chk("abort_state", 32'(o_state), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_addr", {12'd0, o_waddr, o_raddr}, 32'd0);
        chk("abort_idx", o_loop_idx, 32'd0);
        chk("abort_ack", 32'(o_opnd_ack), 32'd0);

        // fill from empty with the consumer held off
        i_loop_size = {8'd1, 8'd1, 8'd4, 8'd4};
        i_opnd_rdy  = 2'b11;
        pulse_start();
        wait_state(3'd2, 10);
        f0 = 0;
        f1 = 0;
        for (int c = 0; c < 10; c++) begin
            f0 += int'(o_opnd_ack[0] & i_opnd_rdy[0]);
            f1 += int'(o_opnd_ack[1] & i_opnd_rdy[1]);
            tick();
        end
        chk("fill_op0", 32'(f0), 32'd4);
        chk("fill_op1", 32'(f1), 32'd2);
        chk("fill_ack_end", 32'(o_opnd_ack), 32'd0);
        chk("fill_main_rdy", 32'(o_main_rdy), 32'd1);

        // full pad: fire blocked while a pop drains it, then fire+pop holds occupancy
        i_main_ack = 1'b1;
        #1;
        chk("sim_blocked", 32'(o_opnd_ack[0]), 32'd0);
        chk("sim_read", 32'(o_read), 32'd3);
        tick();
        chk("sim_ack", 32'(o_opnd_ack[0]), 32'd1);
        chk("sim_write", 32'(o_write[0]), 32'd1);
        tick();
        chk("sim_hold_ack", 32'(o_opnd_ack[0]), 32'd1);
        i_main_ack = 1'b0;
        tick();
        chk("sim_refull", 32'(o_opnd_ack[0]), 32'd0);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("sim_abort_state", 32'(o_state), 32'd0);

        // zero loop sizes behave as one: a single fire finishes the job
        i_loop_size = 32'd0;
        i_pad_size  = {6'd1, 6'd1};
        i_pop_lvl   = {3'd4, 3'd0};
        i_main_ack  = 1'b1;
        pulse_start();
        nz = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_state == 3'd4) break;
            if (o_main_rdy && i_main_ack) begin
                chk("zero_end", 32'(o_loop_end), 32'hF);
                nz++;
            end
        end
        chk("zero_fires", 32'(nz), 32'd1);
        chk("zero_state", 32'(o_state), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
